// File: rtl/gf180mcu_fd_sc_mcu7t5v0__latq_bank.sv
`default_nettype none
// ============================================================================
//  Module   : gf180mcu_fd_sc_mcu7t5v0__latq_bank
//  Brief    : Bank of independent, clocked transparent-latch emulators. Each
//             channel tracks D while its enable is high, checks the enable
//             pulse width and a post-enable hold window, and flags (and in
//             VIOL_MODE=1 also restores and locks) on a timing violation.
//  Revision : 1.0 - initial release
// ============================================================================
module gf180mcu_fd_sc_mcu7t5v0__latq_bank #(
    parameter int WIDTH     = 8,
    parameter int CHANNELS  = 4,
    parameter int MIN_W     = 2,
    parameter int HOLD_CYC  = 1,
    parameter int VIOL_MODE = 0
) (
    input  logic                         CLK,
    input  logic                         RN,
    input  logic [CHANNELS-1:0]          E,
    input  logic [CHANNELS*WIDTH-1:0]    D,
    input  logic                         CLR,
    output logic [CHANNELS*WIDTH-1:0]    Q,
    output logic [CHANNELS-1:0]          VIOL,
    output logic [CHANNELS-1:0]          BUSY
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPEN = 2'd1,
        S_HOLD = 2'd2,
        S_LOCK = 2'd3
    } state_t;

    localparam logic [3:0] c_MIN_W    = 4'(MIN_W);
    localparam logic [3:0] c_HOLD_CYC = 4'(HOLD_CYC);
    localparam logic [3:0] c_WSAT     = 4'hF;

    generate
        for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
            state_t            r_state;
            logic [WIDTH-1:0]  r_q;
            logic [WIDTH-1:0]  r_save;
            logic [3:0]        r_wcnt;
            logic [3:0]        r_hcnt;
            logic              r_viol;

            logic              w_e;
            logic [WIDTH-1:0]  w_d;
            logic              w_short;
            logic              w_hold_bad;

            assign w_e        = E[c];
            assign w_d        = D[c*WIDTH +: WIDTH];
            // Enable fell before the minimum number of open cycles elapsed
            assign w_short    = (r_wcnt < c_MIN_W);
            // Data moved during the hold window
            assign w_hold_bad = (w_d != r_q);

            // Per-channel latch FSM; a violation raised this edge overrides CLR
            always_ff @(posedge CLK) begin
                if (!RN) begin
                    r_state <= S_IDLE;
                    r_q     <= '0;
                    r_save  <= '0;
                    r_wcnt  <= '0;
                    r_hcnt  <= '0;
                    r_viol  <= 1'b0;
                end else begin
                    if (CLR) begin
                        r_viol <= 1'b0;
                    end
                    case (r_state)
                        S_IDLE: begin
                            if (w_e) begin
                                r_state <= S_OPEN;
                                r_save  <= r_q;
                                r_q     <= w_d;
                                r_wcnt  <= 4'd1;
                            end
                        end
                        S_OPEN: begin
                            if (w_e) begin
                                r_q <= w_d;
                                if (r_wcnt != c_WSAT) begin
                                    r_wcnt <= r_wcnt + 4'd1;
                                end
                            end else begin
                                if (w_short) begin
                                    r_viol <= 1'b1;
                                end
                                if (w_short && (VIOL_MODE == 1)) begin
                                    r_q     <= r_save;
                                    r_state <= S_LOCK;
                                end else if (HOLD_CYC == 0) begin
                                    r_state <= S_IDLE;
                                end else begin
                                    r_state <= S_HOLD;
                                    r_hcnt  <= c_HOLD_CYC;
                                end
                            end
                        end
                        S_HOLD: begin
                            if (w_e) begin
                                // Re-opening during hold: no hold check this edge
                                r_state <= S_OPEN;
                                r_save  <= r_q;
                                r_q     <= w_d;
                                r_wcnt  <= 4'd1;
                            end else begin
                                if (w_hold_bad) begin
                                    r_viol <= 1'b1;
                                end
                                if (w_hold_bad && (VIOL_MODE == 1)) begin
                                    r_q     <= r_save;
                                    r_state <= S_LOCK;
                                end else begin
                                    r_hcnt <= r_hcnt - 4'd1;
                                    if (r_hcnt <= 4'd1) begin
                                        r_state <= S_IDLE;
                                    end
                                end
                            end
                        end
                        S_LOCK: begin
                            if (CLR) begin
                                r_state <= S_IDLE;
                            end
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end

            assign Q[c*WIDTH +: WIDTH] = r_q;
            assign VIOL[c]             = r_viol;
            assign BUSY[c]             = (r_state != S_IDLE);
        end
    endgenerate

endmodule
`default_nettype wire

// File: doc/gf180mcu_fd_sc_mcu7t5v0__latq_bank.md
GF180MCU_FD_SC_MCU7T5V0__LATQ_BANK -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__latq_bank

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, data bits per channel (legal 1..32).
REQ-002 SHALL provide parameter CHANNELS, default 4, number of independent latch channels (legal 1..8).
REQ-003 SHALL provide parameter MIN_W, default 2, minimum legal enable-high width in CLK cycles (legal 1..15).
REQ-004 SHALL provide parameter HOLD_CYC, default 1, post-enable hold-check window in CLK cycles (legal 0..15).
REQ-005 SHALL provide parameter VIOL_MODE, default 0: 0 = flag only; 1 = flag, restore and lock.
REQ-006 SHALL provide port CLK  input  1  sole clock; all state updates on its rising edge.
REQ-007 SHALL provide port RN  input  1  reset; synchronous, active-low.
REQ-008 SHALL provide port E  input  CHANNELS  per-channel enable; bit c controls channel c.
REQ-009 SHALL provide port D  input  CHANNELS*WIDTH  data; channel c uses bits [c*WIDTH +: WIDTH].
REQ-010 SHALL provide port CLR  input  1  clears all VIOL bits and releases locked channels.
REQ-011 SHALL provide port Q  output  CHANNELS*WIDTH  registered captured data, same slicing as D.
REQ-012 SHALL provide port VIOL  output  CHANNELS  sticky per-channel timing-violation flag.
REQ-013 SHALL provide port BUSY  output  CHANNELS  high while channel state is not IDLE.

Function
REQ-014 Each channel SHALL run an independent FSM with states IDLE, OPEN, HOLD, LOCK, a 4-bit saturating width counter WCNT, a 4-bit hold counter HCNT and a WIDTH-bit snapshot SAVE.
REQ-015 IDLE, E=1: go OPEN; SAVE<=Q; Q<=D; WCNT<=1.
REQ-016 OPEN, E=1: Q<=D (Q tracks D with 1-cycle latency); WCNT increments, saturating at 15.
REQ-017 OPEN, E=0, WCNT>=MIN_W: Q holds; go HOLD with HCNT<=HOLD_CYC, or go IDLE if HOLD_CYC=0.
REQ-018 OPEN, E=0, WCNT<MIN_W: width violation; VIOL[c]<=1; VIOL_MODE=0 continue as REQ-017; VIOL_MODE=1 Q<=SAVE and go LOCK.
REQ-019 HOLD, E=0: if D slice != Q slice, hold violation, VIOL[c]<=1 (VIOL_MODE=1: Q<=SAVE, go LOCK); else HCNT decrements; go IDLE when HCNT reaches 0 with no violation.
REQ-020 HOLD, E=1: treat as new opening per REQ-015; no hold check that edge.
REQ-021 LOCK: E and D ignored, Q frozen; CLR=1 goes IDLE and clears VIOL[c].
REQ-022 CLR=1 in any state SHALL clear VIOL bits; a violation detected on the same edge SHALL win (VIOL stays 1, LOCK entered).
REQ-023 Channels SHALL NOT interact; activity, violations and locks in one channel SHALL NOT affect another.
REQ-024 BUSY[c] SHALL be derived directly from the registered state (no combinational path from inputs).
REQ-025 Q and VIOL SHALL be registered outputs; no combinational D->Q path.

Reset
REQ-026 RN=0 at a CLK rising edge SHALL force Q=0, VIOL=0, BUSY=0, all FSMs IDLE, WCNT=HCNT=0, SAVE=0, overriding CLR, E and any in-progress window.
REQ-027 RN SHALL have no effect between CLK edges.

Verification (WIDTH=8, CHANNELS=2, MIN_W=2, HOLD_CYC=1 unless stated)
REQ-028 Reset: RN=0 for one edge mid-OPEN with Q=0x5A -> Q=0x0000, VIOL=2'b00, BUSY=2'b00 after that edge.
REQ-029 Normal capture: ch0 E=1 for 3 edges, D0=0x5A stable through 1 cycle after fall -> Q[7:0]=0x5A from first edge, BUSY[0]=1 for 4 edges, VIOL[0]=0.
REQ-030 Width violation: Q0=0x5A, ch0 E=1 for 1 edge with D0=0x33 -> VIOL_MODE=0: Q0=0x33, VIOL[0]=1 sticky; VIOL_MODE=1: Q0 back to 0x5A, LOCK, E pulses ignored until CLR=1.
REQ-031 Hold violation: after valid capture of 0x5A, D0 changes to 0xA5 on the hold edge -> VIOL[0]=1, Q0 remains 0x5A.
REQ-032 Independence/priority: ch1 captures 0xC3 while ch0 is LOCKed -> Q1=0xC3, VIOL[1]=0; CLR=1 on the same edge as a new ch1 width violation -> VIOL[1]=1, VIOL[0]=0.
REQ-033 HOLD_CYC=0 and MIN_W=1: 1-cycle E pulse with D0=0x0F -> Q0=0x0F, BUSY[0]=1 for 1 edge, VIOL=0.
